// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_magnitude_comparator
// Description : Bit-serial MSB-first magnitude comparator for two WIDTH-bit
//               operands. Supports unsigned or two's-complement compare and
//               stops at the first differing bit. A start/busy/done handshake
//               frames each comparison. The gt/eq/lt flags are registered and
//               hold until the next decision.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int             IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic             mode_reg_q, mode_reg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    // Operand bits under examination this cycle
    logic w_bit_a;
    logic w_bit_b;
    assign w_bit_a = a_reg_q[idx_q];
    assign w_bit_b = b_reg_q[idx_q];

    // State register; asynchronous reset aborts any comparison in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, bit index and result flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg_q    <= '0;
            b_reg_q    <= '0;
            mode_reg_q <= 1'b0;
            idx_q      <= '0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            a_reg_q    <= a_reg_d;
            b_reg_q    <= b_reg_d;
            mode_reg_q <= mode_reg_d;
            idx_q      <= idx_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
        end
    end

    // Next-state and datapath update: capture on start, scan MSB-first, decide
    always_comb begin
        state_d    = state_q;
        a_reg_d    = a_reg_q;
        b_reg_d    = b_reg_q;
        mode_reg_d = mode_reg_q;
        idx_d      = idx_q;
        gt_d       = gt_q;
        eq_d       = eq_q;
        lt_d       = lt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A new request is accepted straight out of DONE, so back-to-back
                // comparisons leave no idle gap.
                if (start) begin
                    a_reg_d    = a;
                    b_reg_d    = b;
                    mode_reg_d = signed_mode;
                    idx_d      = IDX_MSB;
                    state_d    = S_SHIFT;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_bit_a != w_bit_b) begin
                    // At the sign bit a set bit means negative, which inverts the sense
                    if (mode_reg_q && (idx_q == IDX_MSB)) begin
                        gt_d = ~w_bit_a;
                        lt_d = w_bit_a;
                    end else begin
                        gt_d = w_bit_a;
                        lt_d = ~w_bit_a;
                    end
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode directly from the registered state
    always_comb begin
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
        gt   = gt_q;
        eq   = eq_q;
        lt   = lt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_magnitude_comparator
// Description : Self-checking bench for serial_magnitude_comparator. Three
//               instances (WIDTH 8, 2, 32); expected flags and latency are
//               queued when a request is driven and compared on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_comparator;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [3];
    logic        mode_v  [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        gt_v    [3];
    logic        eq_v    [3];
    logic        lt_v    [3];

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .signed_mode(mode_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy_v[0]), .done(done_v[0]),
        .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
    );

    serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[1]), .signed_mode(mode_v[1]),
        .a(a_v[1][1:0]), .b(b_v[1][1:0]), .busy(busy_v[1]), .done(done_v[1]),
        .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
    );

    serial_magnitude_comparator #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start_v[2]), .signed_mode(mode_v[2]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2])
    );

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 2 : 32);
    endfunction

    // Reference: sign-bias the operands for signed mode, then compare as integers.
    // Latency is WIDTH minus the highest differing bit index (WIDTH if equal).
    function automatic exp_t ref_model(input int w, input logic [31:0] a,
                                       input logic [31:0] b, input logic m);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] x;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, a} & mask;
        bv   = {32'd0, b} & mask;
        x    = av ^ bv;
        if (m) begin
            av = av ^ (64'd1 << (w - 1));
            bv = bv ^ (64'd1 << (w - 1));
        end
        e.gt  = (av > bv);
        e.eq  = (av == bv);
        e.lt  = (av < bv);
        e.lat = w;
        for (int i = 0; i < w; i++) begin
            if (x[i]) e.lat = w - i;
        end
        return e;
    endfunction

    // Present a request at the falling edge, queue its expectation, release
    // start #1 after the accepting edge.
    task automatic drive_start(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic m, input bit push);
        @(negedge clk);
        start_v[k] = 1'b1;
        a_v[k]     = a;
        b_v[k]     = b;
        mode_v[k]  = m;
        if (push) sb_q.push_back(ref_model(width_of(k), a, b, m));
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
    endtask

    // Count cycles until done is seen (sampled #1 after each rising edge)
    task automatic wait_done(input int k, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int  lat;
        bit  ok;
        bit  seen;
        checks++;
        if ({busy_v[0], done_v[0], gt_v[0], eq_v[0], lt_v[0]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_values got %b want 00000",
                     {busy_v[0], done_v[0], gt_v[0], eq_v[0], lt_v[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        // Leave gt set so the abort has something to clear
        drive_start(0, 32'hA5, 32'h25, 1'b0, 1'b0);
        wait_done(0, lat, ok);
        drive_start(0, 32'h3C, 32'h3C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], gt_v[0], eq_v[0], lt_v[0]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_abort got %b want 00000",
                     {busy_v[0], done_v[0], gt_v[0], eq_v[0], lt_v[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done got activity=1 want 0");
        end
    endtask

    task automatic test_patterns;
        logic [31:0] ta [4] = '{32'hA5, 32'hA5, 32'h12, 32'h3C};
        logic [31:0] tb [4] = '{32'h25, 32'h25, 32'h13, 32'h3C};
        logic        tm [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_t        e;
        int          lat;
        bit          ok;
        logic [2:0]  flags;
        for (int t = 0; t < 4; t++) begin
            drive_start(0, ta[t], tb[t], tm[t], 1'b1);
            checks++;
            if (busy_v[0] !== 1'b1) begin
                errors++;
                $display("FAIL pat%0d_busy got %b want 1", t, busy_v[0]);
            end
            wait_done(0, lat, ok);
            e = sb_q.pop_front();
            checks++;
            if (!ok || lat != e.lat) begin
                errors++;
                $display("FAIL pat%0d_latency got %0d (done=%0d) want %0d", t, lat, ok, e.lat);
            end
            checks++;
            if ({gt_v[0], eq_v[0], lt_v[0], busy_v[0]} !== {e.gt, e.eq, e.lt, 1'b0}) begin
                errors++;
                $display("FAIL pat%0d_flags gt/eq/lt/busy got %b want %b", t,
                         {gt_v[0], eq_v[0], lt_v[0], busy_v[0]}, {e.gt, e.eq, e.lt, 1'b0});
            end
            flags = {gt_v[0], eq_v[0], lt_v[0]};
            @(posedge clk);
            #1;
            checks++;
            if (done_v[0] !== 1'b0 || {gt_v[0], eq_v[0], lt_v[0]} !== flags) begin
                errors++;
                $display("FAIL pat%0d_hold done=%b flags=%b want done=0 flags=%b", t,
                         done_v[0], {gt_v[0], eq_v[0], lt_v[0]}, flags);
            end
        end
    endtask

    task automatic test_ignored_start;
        exp_t e;
        int   lat;
        bit   ok;
        drive_start(0, 32'h12, 32'h13, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 32'hFF;
        b_v[0]     = 32'h00;
        mode_v[0]  = 1'b0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_busy got busy=%b done=%b want 1/0", busy_v[0], done_v[0]);
        end
        wait_done(0, lat, ok);
        lat = lat + 2;
        e = sb_q.pop_front();
        checks++;
        if (!ok || lat != e.lat || {gt_v[0], eq_v[0], lt_v[0]} !== {e.gt, e.eq, e.lt}) begin
            errors++;
            $display("FAIL ignored_start_result got lat=%0d flags=%b want lat=%0d flags=%b",
                     lat, {gt_v[0], eq_v[0], lt_v[0]}, e.lat, {e.gt, e.eq, e.lt});
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        bit   ok;
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 32'hA5;
        b_v[0]     = 32'h25;
        mode_v[0]  = 1'b0;
        sb_q.push_back(ref_model(8, 32'hA5, 32'h25, 1'b0));
        @(posedge clk);
        #1;
        wait_done(0, lat, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || lat != e.lat || {gt_v[0], eq_v[0], lt_v[0]} !== {e.gt, e.eq, e.lt}) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d flags=%b want lat=%0d flags=%b",
                     lat, {gt_v[0], eq_v[0], lt_v[0]}, e.lat, {e.gt, e.eq, e.lt});
        end
        // start still high during DONE: the new operands are taken on the next edge
        a_v[0] = 32'h10;
        b_v[0] = 32'h30;
        sb_q.push_back(ref_model(8, 32'h10, 32'h30, 1'b0));
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy_v[0], done_v[0]);
        end
        wait_done(0, lat, ok);
        e = sb_q.pop_front();
        checks++;
        if (!ok || lat != e.lat || {gt_v[0], eq_v[0], lt_v[0]} !== {e.gt, e.eq, e.lt}) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d flags=%b want lat=%0d flags=%b",
                     lat, {gt_v[0], eq_v[0], lt_v[0]}, e.lat, {e.gt, e.eq, e.lt});
        end
    endtask

    task automatic test_sweep;
        exp_t        e;
        int          lat;
        bit          ok;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int k = 1; k < 3; k++) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 6; i++) begin
                    ra = $urandom;
                    rb = (i == 0) ? ra : ((i == 1) ? (ra ^ 32'h1) : $urandom);
                    drive_start(k, ra, rb, m[0], 1'b1);
                    wait_done(k, lat, ok);
                    e = sb_q.pop_front();
                    checks++;
                    if (!ok || lat != e.lat ||
                        {gt_v[k], eq_v[k], lt_v[k]} !== {e.gt, e.eq, e.lt}) begin
                        errors++;
                        $display("FAIL sweep_w%0d_m%0d a=%h b=%h got lat=%0d flags=%b want lat=%0d flags=%b",
                                 width_of(k), m, ra, rb, lat, {gt_v[k], eq_v[k], lt_v[k]},
                                 e.lat, {e.gt, e.eq, e.lt});
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            mode_v[k]  = 1'b0;
            a_v[k]     = '0;
            b_v[k]     = '0;
        end
        #3;
        test_reset;
        test_patterns;
        test_ignored_start;
        test_back_to_back;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
